imm_alu_control_unit: RTL and testbench

- Hardwired control FSM that sequences the datapath through fetch (T0–T2) and execute (T3–T5) for register-register and immediate ALU instructions.
- Drives the datapath control strobes (PCout, MAR_enable, IncPC, ZLowIn/ZLowout, MDR_read/MDR_enable/MDRout, IR_enable, Gra/Grb/Grc, R_in/R_out, Y_enable, Cout) and the ALU operation select.
- Replaces hand-written bench stimulus; sits beside the datapath and reads back the latched IR.

---
 rtl/imm_alu_control_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_imm_alu_control_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_alu_control_unit.sv
// imm_alu_control_unit
// Hardwired control sequencer for the datapath. Each instruction is fetched
// in T0-T2 and executed in T3-T5, for register-register and immediate ALU
// instructions.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Clear      in   synchronous active-low reset
//   IR[31:0]   in   latched instruction register from the datapath
//   Mem_ready  in   memory read data valid (only looked at in T1)
//   Stop       in   pause request, honoured at the next instruction boundary
//   PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable, MDR_read,
//   MDR_enable, MDRout, IR_enable                  out  datapath strobes
//   Gra, Grb, Grc, R_in, R_out, Y_enable, Cout     out  register/bus strobes
//   ALU_op[4:0] out  ALU operation; nonzero only in T4
//   Run        out  high while an instruction is being sequenced (T0-T5)
//   Illegal    out  one-cycle pulse in T3 for an undefined opcode
//   Fault      out  sticky fetch-timeout flag, cleared only by Clear
module imm_alu_control_unit #(
  parameter int FETCH_TIMEOUT = 15,
  parameter int OPW           = 5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        MAR_enable,
  output logic        IncPC,
  output logic        ZLowIn,
  output logic        ZLowout,
  output logic        PC_enable,
  output logic        MDR_read,
  output logic        MDR_enable,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        Y_enable,
  output logic        Cout,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic        Illegal,
  output logic        Fault
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [3:0] ST_RST     = 4'd0;
  localparam logic [3:0] ST_T0      = 4'd1;
  localparam logic [3:0] ST_T1      = 4'd2;
  localparam logic [3:0] ST_T2      = 4'd3;
  localparam logic [3:0] ST_T3      = 4'd4;
  localparam logic [3:0] ST_T4      = 4'd5;
  localparam logic [3:0] ST_T5      = 4'd6;
  localparam logic [3:0] ST_STOPPED = 4'd7;
  localparam logic [3:0] ST_HALTED  = 4'd8;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  logic [3:0]     state_r, state_nx_s;
  logic [CW-1:0]  wait_cnt_r, wait_cnt_nx_s;
  logic           fault_r, fault_nx_s;
  logic [OPW-1:0] opcode_s;
  logic           rtype_s, imm_s;
  logic           ir_unused_s;

  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_imm(input logic [OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Immediate forms reuse the register-register ALU code of the same operation.
  function automatic logic [4:0] imm_alu_code(input logic [OPW-1:0] op);
    logic [4:0] code;
    case (op)
      OP_ADDI: code = 5'(OP_ADD);
      OP_ANDI: code = 5'(OP_AND);
      OP_ORI:  code = 5'(OP_OR);
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  assign opcode_s    = IR[31:32-OPW];
  assign rtype_s     = is_rtype(opcode_s);
  assign imm_s       = is_imm(opcode_s);
  // Operand fields are consumed by the datapath, not by the sequencer.
  assign ir_unused_s = ^IR[31-OPW:0];
  assign Fault       = fault_r;

  // Next-state, fetch wait counter and sticky fault.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    fault_nx_s    = fault_r;
    case (state_r)
      ST_RST: state_nx_s = ST_T0;
      ST_T0: begin
        state_nx_s    = ST_T1;
        wait_cnt_nx_s = '0;
      end
      ST_T1: begin
        if (Mem_ready) begin
          state_nx_s = ST_T2;
        end else if (wait_cnt_r == CW'(FETCH_TIMEOUT - 1)) begin
          // Last permitted wait cycle expired without data.
          state_nx_s = ST_HALTED;
          fault_nx_s = 1'b1;
        end else begin
          wait_cnt_nx_s = wait_cnt_r + CW'(1);
        end
      end
      ST_T2: state_nx_s = ST_T3;
      ST_T3: begin
        if (rtype_s || imm_s) begin
          state_nx_s = ST_T4;
        end else if (opcode_s == OP_HALT) begin
          state_nx_s = ST_HALTED;
        end else if (Stop) begin
          state_nx_s = ST_STOPPED;
        end else begin
          state_nx_s = ST_T0;
        end
      end
      ST_T4: state_nx_s = ST_T5;
      ST_T5: state_nx_s = Stop ? ST_STOPPED : ST_T0;
      ST_STOPPED: begin
        if (!Stop) begin
          state_nx_s = ST_T0;
        end else begin
          state_nx_s = ST_STOPPED;
        end
      end
      ST_HALTED: state_nx_s = ST_HALTED;
      default:   state_nx_s = ST_RST;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_r    <= ST_RST;
      wait_cnt_r <= '0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
      fault_r    <= fault_nx_s;
    end
  end

  // Strobe decode from the registered state; only T1 looks at Mem_ready.
  always_comb begin
    PCout      = 1'b0;
    MAR_enable = 1'b0;
    IncPC      = 1'b0;
    ZLowIn     = 1'b0;
    ZLowout    = 1'b0;
    PC_enable  = 1'b0;
    MDR_read   = 1'b0;
    MDR_enable = 1'b0;
    MDRout     = 1'b0;
    IR_enable  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    R_in       = 1'b0;
    R_out      = 1'b0;
    Y_enable   = 1'b0;
    Cout       = 1'b0;
    ALU_op     = 5'b00000;
    Run        = 1'b0;
    Illegal    = 1'b0;
    case (state_r)
      ST_T0: begin
        Run        = 1'b1;
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        ZLowIn     = 1'b1;
      end
      ST_T1: begin
        Run        = 1'b1;
        ZLowout    = 1'b1;
        MDR_read   = 1'b1;
        PC_enable  = Mem_ready;
        MDR_enable = Mem_ready;
      end
      ST_T2: begin
        Run       = 1'b1;
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      ST_T3: begin
        Run = 1'b1;
        if (rtype_s || imm_s) begin
          Grb      = 1'b1;
          R_out    = 1'b1;
          Y_enable = 1'b1;
        end else if ((opcode_s == OP_NOP) || (opcode_s == OP_HALT)) begin
          Illegal = 1'b0;
        end else begin
          Illegal = 1'b1;
        end
      end
      ST_T4: begin
        Run    = 1'b1;
        ZLowIn = 1'b1;
        if (imm_s) begin
          Cout   = 1'b1;
          ALU_op = imm_alu_code(opcode_s);
        end else begin
          Grc    = 1'b1;
          R_out  = 1'b1;
          ALU_op = 5'(opcode_s);
        end
      end
      ST_T5: begin
        Run     = 1'b1;
        ZLowout = 1'b1;
        Gra     = 1'b1;
        R_in    = 1'b1;
      end
      default: Run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_imm_alu_control_unit.sv
module tb_imm_alu_control_unit;

  logic        Clock = 1'b0;
  logic        Clear, Mem_ready, Stop;
  logic [31:0] IR;
  logic PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable, MDR_read;
  logic MDR_enable, MDRout, IR_enable, Gra, Grb, Grc, R_in, R_out, Y_enable, Cout;
  logic [4:0] ALU_op;
  logic Run, Illegal, Fault;

  always #5 Clock = ~Clock;

  imm_alu_control_unit #(.FETCH_TIMEOUT(15), .OPW(5)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .MAR_enable(MAR_enable), .IncPC(IncPC), .ZLowIn(ZLowIn),
    .ZLowout(ZLowout), .PC_enable(PC_enable), .MDR_read(MDR_read),
    .MDR_enable(MDR_enable), .MDRout(MDRout), .IR_enable(IR_enable),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out),
    .Y_enable(Y_enable), .Cout(Cout), .ALU_op(ALU_op), .Run(Run),
    .Illegal(Illegal), .Fault(Fault)
  );

  typedef struct packed {
    logic PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable, MDR_read;
    logic MDR_enable, MDRout, IR_enable, Gra, Grb, Grc, R_in, R_out, Y_enable, Cout;
    logic [4:0] ALU_op;
    logic Run, Illegal, Fault;
  } outs_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  outs_t act_s;
  assign act_s = {PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable, MDR_read,
                  MDR_enable, MDRout, IR_enable, Gra, Grb, Grc, R_in, R_out,
                  Y_enable, Cout, ALU_op, Run, Illegal, Fault};

  outs_t exp_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    fault_m  = 1'b0;

  // Instruction classes: 0 register ALU, 1 immediate ALU, 2 NOP, 3 HALT, 4 undefined.
  function automatic int op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 0;
      OP_ADDI, OP_ANDI, OP_ORI:      return 1;
      OP_NOP:                        return 2;
      OP_HALT:                       return 3;
      default:                       return 4;
    endcase
  endfunction

  function automatic logic [4:0] imm_code(input logic [4:0] op);
    case (op)
      OP_ADDI: return 5'b00011;
      OP_ANDI: return 5'b00101;
      OP_ORI:  return 5'b00110;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic outs_t idle_v();
    outs_t v = '0;
    v.Fault = fault_m;
    return v;
  endfunction

  function automatic outs_t t0_v();
    outs_t v = idle_v();
    v.Run = 1'b1; v.PCout = 1'b1; v.MAR_enable = 1'b1; v.IncPC = 1'b1; v.ZLowIn = 1'b1;
    return v;
  endfunction

  function automatic outs_t t1_v(input logic mr);
    outs_t v = idle_v();
    v.Run = 1'b1; v.ZLowout = 1'b1; v.MDR_read = 1'b1;
    v.PC_enable = mr; v.MDR_enable = mr;
    return v;
  endfunction

  function automatic outs_t t2_v();
    outs_t v = idle_v();
    v.Run = 1'b1; v.MDRout = 1'b1; v.IR_enable = 1'b1;
    return v;
  endfunction

  function automatic outs_t t3_v(input logic [4:0] op);
    outs_t v = idle_v();
    v.Run = 1'b1;
    if (op_class(op) <= 1) begin
      v.Grb = 1'b1; v.R_out = 1'b1; v.Y_enable = 1'b1;
    end
    if (op_class(op) == 4) v.Illegal = 1'b1;
    return v;
  endfunction

  function automatic outs_t t4_v(input logic [4:0] op);
    outs_t v = idle_v();
    v.Run = 1'b1; v.ZLowIn = 1'b1;
    if (op_class(op) == 1) begin
      v.Cout = 1'b1; v.ALU_op = imm_code(op);
    end else begin
      v.Grc = 1'b1; v.R_out = 1'b1; v.ALU_op = op;
    end
    return v;
  endfunction

  function automatic outs_t t5_v();
    outs_t v = idle_v();
    v.Run = 1'b1; v.ZLowout = 1'b1; v.Gra = 1'b1; v.R_in = 1'b1;
    return v;
  endfunction

  // Compare DUT outputs with the model's expectation for this cycle, mid-cycle.
  always @(negedge Clock) begin
    outs_t e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      n_checks++;
      if (act_s !== e) begin
        n_fail++;
        $display("FAIL %s: outputs got %h want %h", n, act_s, e);
      end
    end
  end

  task automatic step(input outs_t e, input string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
    @(posedge Clock);
    #1;
  endtask

  task automatic lit(input string n, input logic [4:0] a, input logic [4:0] w);
    n_checks++;
    if (a !== w) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", n, a, w);
    end
  endtask

  task automatic fetch(input logic [4:0] op, input int stalls, input string n);
    IR = {op, 27'h5A5A5A5};
    Mem_ready = 1'b0;
    step(t0_v(), {n, "_t0"});
    for (int i = 0; i < stalls; i++) step(t1_v(1'b0), {n, "_t1wait"});
    Mem_ready = 1'b1;
    #2;
    lit({n, "_pcen"}, 5'(PC_enable), 5'b00001);
    step(t1_v(1'b1), {n, "_t1"});
    Mem_ready = 1'b0;
    step(t2_v(), {n, "_t2"});
  endtask

  task automatic execute(input logic [4:0] op, input string n);
    step(t3_v(op), {n, "_t3"});
    if (op_class(op) <= 1) begin
      step(t4_v(op), {n, "_t4"});
      step(t5_v(), {n, "_t5"});
    end
  endtask

  initial begin
    Clear = 1'b0; Mem_ready = 1'b0; Stop = 1'b0; IR = 32'h0000_0000;
    @(posedge Clock);
    #1;
    step(idle_v(), "rst_hold");
    Clear = 1'b1;
    step(idle_v(), "rst_exit");

    // ORI, no wait states
    fetch(OP_ORI, 0, "ori");
    step(t3_v(OP_ORI), "ori_t3");
    #2;
    lit("ori_t4_aluop", ALU_op, 5'b00110);
    lit("ori_t4_cout", 5'(Cout), 5'b00001);
    step(t4_v(OP_ORI), "ori_t4");
    #2;
    lit("ori_t5_rin", 5'(R_in), 5'b00001);
    step(t5_v(), "ori_t5");
    #2;
    lit("ori_next_pcout", 5'(PCout), 5'b00001);

    // ADD with three wait cycles in T1
    fetch(OP_ADD, 3, "add");
    step(t3_v(OP_ADD), "add_t3");
    #2;
    lit("add_t4_aluop", ALU_op, 5'b00011);
    step(t4_v(OP_ADD), "add_t4");
    step(t5_v(), "add_t5");

    // NOP and undefined opcode: four cycles each, back to T0
    fetch(OP_NOP, 0, "nop");
    execute(OP_NOP, "nop");
    fetch(OP_BAD, 0, "ill");
    #2;
    lit("ill_pulse", 5'(Illegal), 5'b00001);
    step(t3_v(OP_BAD), "ill_t3");

    // ADDI with Stop raised in T4
    fetch(OP_ADDI, 0, "addi");
    step(t3_v(OP_ADDI), "addi_t3");
    Stop = 1'b1;
    step(t4_v(OP_ADDI), "addi_t4");
    step(t5_v(), "addi_t5");
    #2;
    lit("stopped_run", 5'(Run), 5'b00000);
    step(idle_v(), "stopped1");
    step(idle_v(), "stopped2");
    Stop = 1'b0;
    step(idle_v(), "stopped_exit");

    for (int k = 0; k < 3; k++) begin
      logic [4:0] op;
      op = (k == 0) ? OP_SUB : (k == 1) ? OP_AND : OP_OR;
      fetch(op, k, "rr");
      execute(op, "rr");
    end

    // Clear during T4 of ANDI
    fetch(OP_ANDI, 0, "andi");
    step(t3_v(OP_ANDI), "andi_t3");
    Clear = 1'b0;
    step(t4_v(OP_ANDI), "andi_t4_clr");
    Clear = 1'b1;
    #2;
    lit("clr_zlowin", 5'(ZLowIn), 5'b00000);
    lit("clr_cout", 5'(Cout), 5'b00000);
    lit("clr_aluop", ALU_op, 5'b00000);
    step(idle_v(), "clr_rst");
    fetch(OP_ADDI, 1, "addi2");
    execute(OP_ADDI, "addi2");

    // HALT opcode
    fetch(OP_HALT, 0, "halt");
    execute(OP_HALT, "halt");
    step(idle_v(), "halted1");
    Mem_ready = 1'b1;
    step(idle_v(), "halted2");
    Mem_ready = 1'b0;
    Clear = 1'b0;
    step(idle_v(), "halted_clr");
    Clear = 1'b1;
    step(idle_v(), "halt_rst");

    // Fetch timeout: 15 cycles in T1 without data
    IR = {OP_ADD, 27'h0000123};
    step(t0_v(), "to_t0");
    for (int i = 0; i < 15; i++) step(t1_v(1'b0), "to_t1wait");
    fault_m = 1'b1;
    #2;
    lit("to_fault", 5'(Fault), 5'b00001);
    lit("to_run", 5'(Run), 5'b00000);
    for (int i = 0; i < 3; i++) step(idle_v(), "to_halted");
    Clear = 1'b0;
    step(idle_v(), "to_clr");
    fault_m = 1'b0;
    Clear = 1'b1;
    #2;
    lit("to_fault_cleared", 5'(Fault), 5'b00000);
    step(idle_v(), "to_rst");
    step(t0_v(), "to_t0_again");

    @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
